spi_flash_sched: RTL and testbench
==================================

// Module: spi_flash_sched
// PURPOSE
//  Two-port scheduler and sequencer for the shared SPI flash ROM. Port 0 is the video line-prefetch
//  requester; port 1 is an auxiliary requester (e.g. palette/tile loader).
//  The block arbitrates between the ports and runs one READ (03h) transaction per grant: 8 cmd bits,
//  then 24 addr bits, then LEN bytes. Received bytes are streamed back tagged with the owning port.
//  It is the single owner of spi_cs/spi_sclk/spi_mosi; nothing else drives the flash.
// PARAMETERS
//  LEN_W    8  width of byte-count request; length 0 is illegal and is treated as 1
//  CS_GAP   2  minimum clk cycles with spi_cs low between transactions (>=1)
// PORTS
//  clk        in   1   system clock, single clock domain
//  reset      in   1   synchronous, active-high
//  req0       in   1   port 0 request (level); held until gnt0
//  addr0      in   24  port 0 start byte address, sampled on gnt0
//  len0       in   LEN_W port 0 byte count, sampled on gnt0
//  req1       in   1   port 1 request (level)
//  addr1      in   24  port 1 start address
//  len1       in   LEN_W port 1 byte count
//  gnt0       out  1   1-cycle pulse: port 0 accepted
//  gnt1       out  1   1-cycle pulse: port 1 accepted
//  rd_data    out  8   received byte, MSB first on the wire
//  rd_valid   out  1   1-cycle pulse: rd_data valid
//  rd_port    out  1   owner of rd_data (0/1)
//  rd_last    out  1   with rd_valid: final byte of transaction
//  busy       out  1   high from grant cycle to return to IDLE
//  spi_cs     out  1   chip select, ACTIVE HIGH (inverted at pad)
//  spi_sclk   out  1   SPI clock, mode 0, registered, = clk/2 while active
//  spi_mosi   out  1   SPI data out
//  spi_miso   in   1   SPI data in
// BEHAVIOUR
//  Reset: IDLE; spi_cs=0, spi_sclk=0, spi_mosi=0, gnt*=0, rd_valid=0, rd_last=0, rd_port=0,
//   rd_data=0, busy=0, gap counter preloaded so IDLE may grant immediately. Reset mid-transaction aborts:
//   outputs take reset values next cycle; no rd_valid is emitted for the partial byte.
//  States: IDLE -> CMD -> ADDR -> DATA -> GAP -> IDLE.
//  IDLE: if gap done and any req: grant (fixed priority, port 0 wins if both); pulse gntN, latch addr/len/port,
//   load shift reg {8'h03, addr}, spi_cs<=1, busy<=1, drive MOSI=bit31 (0) -> CMD.
//  Bit timing: phase flop toggles every clk while in CMD/ADDR/DATA; spi_sclk=phase.
//   phase 0->1 (SCLK rise): flash samples MOSI; block samples MISO (DATA only).
//   phase 1->0 (SCLK fall): shift next MOSI bit out; bit counter increments.
//   One SPI bit = 2 clk; 32 preamble bits = 64 clk after grant.
//  CMD (bits 0-7) -> ADDR (bits 8-31) on 8th fall; ADDR -> DATA on 32nd fall; MOSI=0 throughout DATA.
//  DATA: MISO shifted in MSB first; on the rise that samples bit 7 of a byte, the byte is registered and
//   rd_valid pulses the following cycle with rd_port; rd_last set on byte LEN-1.
//  After last byte's sampling rise: next fall returns spi_sclk to 0, spi_cs<=0 same cycle -> GAP.
//  GAP: hold cs low CS_GAP cycles; busy drops on GAP->IDLE. Requests arriving mid-transaction wait;
//   no preemption. Port 1 can starve while req0 held; this is the intended policy (video first).
//  Byte count arithmetic: LEN_W-bit down-counter; len 0 treated as 1; addresses wrap at 24 bits (flash).
//  req deasserted before grant: no grant; addr/len ignored except on the grant cycle.
//  Transaction latency: gnt -> first rd_valid = 64 + 16 + 1 = 81 clk; total cs-high = 64 + 16*LEN clk.
// TESTING
//  1 reset then req0, addr0=24'h000140, len0=4 -> gnt0 @t, MOSI stream 03h,000140h; 4 rd_valid, rd_port=0,
//    first @t+81, spacing 16 clk, rd_last on 4th; cs high exactly 128 clk.
//  2 req0 and req1 same cycle -> gnt0 only; gnt1 at first IDLE cycle after GAP (CS_GAP=2).
//  3 flash model returns A5h,3Ch -> rd_data A5h then 3Ch; len=2 rd_last on 3Ch.
//  4 len1=0, port 1 only -> exactly 1 byte, rd_port=1, rd_last=1.
//  5 reset asserted at DATA bit 3 -> next cycle spi_cs=0, busy=0, no rd_valid; fresh req0 granted normally.
//  6 check spi_sclk only toggles while spi_cs=1; MOSI stable across every SCLK rise.

Source files
------------

// File: rtl/spi_flash_sched.sv
// spi_flash_sched: two-port fixed-priority scheduler and SPI-mode-0 READ (03h) sequencer for the shared flash
module spi_flash_sched #(
    parameter int LEN_W  = 8,
    parameter int CS_GAP = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [23:0]      addr0,
    input  logic [LEN_W-1:0] len0,
    input  logic             req1,
    input  logic [23:0]      addr1,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_port,
    output logic             rd_last,
    output logic             busy,
    output logic             spi_cs,
    output logic             spi_sclk,
    output logic             spi_mosi,
    input  logic             spi_miso
);
    localparam int GW = $clog2(CS_GAP + 1);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, GAP} state_t;
    state_t state_q, state_d;
    logic phase_q, phase_d, rdy_q, rdy_d, port_q, port_d, cs_q, cs_d;
    logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d, rd_port_q, rd_port_d;
    logic [4:0] bit_q, bit_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0] in_q, in_d, rd_data_q, rd_data_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, len_sel;
    logic [GW-1:0] gap_q, gap_d;
    logic go, active, rise, fall;
    assign active  = state_q inside {CMD, ADDR, DATA};
    assign rise    = active && !phase_q;
    assign fall    = active && phase_q;
    assign go      = state_q == IDLE && gap_q == GW'(CS_GAP) && !reset && (req0 || req1);
    assign len_sel = req0 ? len0 : len1;
    assign gnt0     = go && req0;
    assign gnt1     = go && !req0;
    assign busy     = state_q != IDLE;
    assign spi_cs   = cs_q;
    assign spi_sclk = phase_q;
    assign spi_mosi = sh_q[31];
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_port  = rd_port_q;
    assign rd_last  = rd_last_q;
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        rdy_d      = rdy_q;
        port_d     = port_q;
        cs_d       = cs_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        in_d       = in_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rd_data_d  = rd_data_q;
        rd_port_d  = rd_port_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        case (state_q)
            IDLE: if (go) begin
                state_d = CMD;
                port_d  = !req0;
                sh_d    = {8'h03, req0 ? addr0 : addr1};
                cnt_d   = len_sel == '0 ? LEN_W'(1) : len_sel;
                cs_d    = 1'b1;
                phase_d = 1'b0;
                bit_d   = '0;
                rdy_d   = 1'b0;
            end
            CMD, ADDR, DATA: begin
                phase_d = !phase_q;
                if (rise && state_q == DATA) begin
                    in_d  = {in_q[6:0], spi_miso};
                    rdy_d = bit_q[2:0] == 3'd7;
                end
                if (fall) begin
                    sh_d    = {sh_q[30:0], 1'b0};
                    bit_d   = bit_q + 5'd1;
                    state_d = (state_q == CMD && bit_q == 5'd7) ? ADDR :
                              (state_q == ADDR && bit_q == 5'd31) ? DATA : state_q;
                    if (rdy_q) begin
                        rdy_d      = 1'b0;
                        rd_valid_d = 1'b1;
                        rd_data_d  = in_q;
                        rd_port_d  = port_q;
                        rd_last_d  = cnt_q == LEN_W'(1);
                        cnt_d      = cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = GAP;
                            cs_d    = 1'b0;
                            gap_d   = '0;
                        end
                    end
                end
            end
            GAP: begin
                gap_d   = gap_q + 1'b1;
                state_d = gap_q == GW'(CS_GAP - 1) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= 1'b0;
            rdy_q      <= 1'b0;
            port_q     <= 1'b0;
            cs_q       <= 1'b0;
            bit_q      <= '0;
            sh_q       <= '0;
            in_q       <= '0;
            cnt_q      <= '0;
            gap_q      <= GW'(CS_GAP);
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_port_q  <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            rdy_q      <= rdy_d;
            port_q     <= port_d;
            cs_q       <= cs_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            in_q       <= in_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_port_q  <= rd_port_d;
            rd_last_q  <= rd_last_d;
        end
    end
endmodule

// File: tb/tb_spi_flash_sched.sv
// tb_spi_flash_sched: random + directed requests, flash device model and timing scoreboard
module tb_spi_flash_sched;
    localparam int LEN_W = 8, CS_GAP = 2;
    logic clk = 1'b0, reset = 1'b1, req0 = 1'b0, req1 = 1'b0, spi_miso = 1'b0;
    logic [23:0] addr0 = '0, addr1 = '0;
    logic [LEN_W-1:0] len0 = '0, len1 = '0;
    logic gnt0, gnt1, rd_valid, rd_port, rd_last, busy, spi_cs, spi_sclk, spi_mosi;
    logic [7:0] rd_data;
    always #5 clk = ~clk;
    spi_flash_sched #(.LEN_W(LEN_W), .CS_GAP(CS_GAP)) dut (
        .clk(clk), .reset(reset), .req0(req0), .addr0(addr0), .len0(len0),
        .req1(req1), .addr1(addr1), .len1(len1), .gnt0(gnt0), .gnt1(gnt1),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_port(rd_port), .rd_last(rd_last),
        .busy(busy), .spi_cs(spi_cs), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso));
    typedef struct {int cyc; logic [7:0] d; logic p; logic last;} exp_t;
    exp_t sb[$];
    int errors = 0, checks = 0, cyc = 0;
    int cs_lo = -100, cs_hi = -100, busy_hi = -100, earliest = 0, nbits = 0;
    logic rst_e = 1'b0, psclk = 1'b0, pmosi = 1'b0;
    logic [23:0] exp_addr = '0;
    logic [31:0] sr = '0;
    // flash contents: a fixed pattern plus two known bytes
    function automatic logic [7:0] mem(input logic [23:0] a);
        if (a == 24'h00ABC0) return 8'hA5;
        if (a == 24'h00ABC1) return 8'h3C;
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    always @(posedge clk) begin
        cyc++;
        rst_e = reset;
    end
    always @(negedge clk) begin : mon
        int L, k;
        logic eg;
        logic [7:0] b;
        exp_t e;
        if (rst_e) begin
            cs_lo = -100; cs_hi = -100; busy_hi = -100; earliest = 0;
            sb.delete();
        end
        eg = !reset && cyc >= earliest && (req0 || req1);
        chk("gnt0", gnt0, eg && req0);
        chk("gnt1", gnt1, eg && !req0);
        chk("spi_cs", spi_cs, cyc >= cs_lo && cyc <= cs_hi);
        chk("busy", busy, cyc >= cs_lo && cyc <= busy_hi);
        chk("sclk_without_cs", spi_sclk && !spi_cs, 0);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_byte @cyc %0d: got none expected %0h at cyc %0d", cyc, sb[0].d, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rd_valid @cyc %0d: got %0h expected no byte", cyc, rd_data);
            end else begin
                e = sb.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_data", rd_data, e.d);
                chk("rd_port", rd_port, e.p);
                chk("rd_last", rd_last, e.last);
            end
        end
        if (eg) begin
            L = int'(req0 ? len0 : len1);
            if (L == 0) L = 1;
            exp_addr = req0 ? addr0 : addr1;
            cs_lo = cyc + 1; cs_hi = cyc + 64 + 16 * L;
            busy_hi = cs_hi + CS_GAP; earliest = busy_hi + 1;
            for (int i = 0; i < L; i++)
                sb.push_back(exp_t'{cyc + 81 + 16 * i, mem(exp_addr + 24'(i)), !req0, i == L - 1});
        end
        if (!spi_cs) nbits = 0;
        else if (spi_sclk && !psclk) begin
            chk("mosi_stable", spi_mosi, pmosi);
            if (nbits < 32) begin
                sr = {sr[30:0], spi_mosi};
                if (nbits == 31) chk("cmd_addr", sr, {8'h03, exp_addr});
            end
            nbits++;
        end else if (!spi_sclk && psclk && nbits >= 32) begin
            k = nbits - 32;
            b = mem(sr[23:0] + 24'(k / 8));
            spi_miso = b[7 - k % 8];
        end
        psclk = spi_sclk;
        pmosi = spi_mosi;
    end
    task automatic run(input logic r0, input logic r1, input logic [23:0] a0, input logic [23:0] a1,
                       input logic [7:0] l0, input logic [7:0] l1);
        logic g0, g1;
        int t;
        g0 = !r0; g1 = !r1; t = 0;
        @(posedge clk); #1;
        req0 = r0; req1 = r1; addr0 = a0; addr1 = a1; len0 = l0; len1 = l1;
        while (!(g0 && g1) && t < 3000) begin
            @(negedge clk);
            g0 = g0 || gnt0;
            g1 = g1 || gnt1;
            @(posedge clk); #1;
            if (g0) begin req0 = 1'b0; addr0 = 24'($urandom); len0 = 8'($urandom); end
            if (g1) begin req1 = 1'b0; addr1 = 24'($urandom); len1 = 8'($urandom); end
            t++;
        end
        if (t >= 3000) begin
            checks++; errors++;
            $display("FAIL grant_timeout: got g0=%0b g1=%0b expected both granted", g0, g1);
            req0 = 1'b0; req1 = 1'b0;
        end
    endtask
    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy || sb.size() > 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, sb.size());
        end
        #1;
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end
    initial begin
        logic r0, r1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run(1, 0, 24'h000140, 24'h0, 8'd4, 8'd0); wait_idle();
        run(1, 1, 24'h001000, 24'h002000, 8'd3, 8'd2); wait_idle();
        run(0, 1, 24'h0, 24'h00ABC0, 8'd0, 8'd2); wait_idle();
        run(1, 0, 24'h00ABC0, 24'h0, 8'd2, 8'd0); wait_idle();
        run(0, 1, 24'h0, 24'h123456, 8'd0, 8'd0); wait_idle();
        run(1, 0, 24'hFFFFFE, 24'h0, 8'd4, 8'd0); wait_idle();
        run(1, 0, 24'h000200, 24'h0, 8'd3, 8'd0);
        repeat (71) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        run(1, 0, 24'h000300, 24'h0, 8'd1, 8'd0); wait_idle();
        for (int n = 0; n < 30; n++) begin
            r0 = 1'($urandom); r1 = 1'($urandom);
            if (!r0 && !r1) r1 = 1'b1;
            run(r0, r1, 24'($urandom), 24'($urandom),
                8'($urandom_range(0, 7) == 0 ? $urandom_range(0, 20) : $urandom_range(0, 4)),
                8'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0) begin
                repeat (3) @(posedge clk);
                #1 req1 = 1'b1; addr1 = 24'($urandom);
                repeat (5) @(posedge clk);
                #1 req1 = 1'b0;
            end
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();
        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
